// File: rtl/if_pipe_reg_skid.sv
// ---------------------------------------------------------------------------
// if_pipe_reg_skid
//
// Fetch/decode pipeline register with valid/ready handshaking and a 2-entry
// skid buffer. The head entry is always the oldest and drives decode directly.
// The skid entry catches one extra instruction so that in_ready never depends
// combinationally on out_ready. A branch flush drops everything held.
// Saturating stall and flush counters are exposed for performance debug.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   fetch presents in_pc / in_instr
//   in_ready   block can accept this cycle
//   in_pc      fetched PC
//   in_instr   fetched instruction
//   freeze     hazard stall: no transfers, contents held
//   flush      branch-taken flush: all held entries discarded
//   out_valid  head entry presented to decode
//   out_ready  decode consumes the head entry
//   out_pc     PC of head entry (0 when empty)
//   out_instr  instruction of head entry (0 when empty, i.e. a NOP bubble)
//   stall_cnt  cycles a held head entry was not consumed
//   flush_cnt  flush cycles that discarded at least one valid entry
// ---------------------------------------------------------------------------
module if_pipe_reg_skid #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               freeze,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]         state,      nxt_state;
  logic [PC_W-1:0]    head_pc,    nxt_head_pc;
  logic [INSTR_W-1:0] head_instr, nxt_head_instr;
  logic [PC_W-1:0]    skid_pc,    nxt_skid_pc;
  logic [INSTR_W-1:0] skid_instr, nxt_skid_instr;

  logic accept;
  logic issue;
  logic stall_hit;
  logic flush_hit;

  // Handshake outputs depend only on registered state plus freeze/flush,
  // so there is no combinational path from out_ready to in_ready.
  assign in_ready  = (state != FULL) && !freeze && !flush;
  assign out_valid = (state != EMPTY) && !freeze;
  assign out_pc    = head_pc;
  assign out_instr = head_instr;

  assign accept = in_valid && in_ready;
  // A flush cycle never counts as a transfer even if decode raised out_ready.
  assign issue  = out_valid && out_ready && !flush;

  assign stall_hit = (state != EMPTY) && !flush && (freeze || !out_ready);
  assign flush_hit = flush && (state != EMPTY);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would infer a latch.
    nxt_state      = state;
    nxt_head_pc    = head_pc;
    nxt_head_instr = head_instr;
    nxt_skid_pc    = skid_pc;
    nxt_skid_instr = skid_instr;

    if (flush) begin
      nxt_state      = EMPTY;
      nxt_head_pc    = '0;
      nxt_head_instr = '0;
      nxt_skid_pc    = '0;
      nxt_skid_instr = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            nxt_state      = ONE;
            nxt_head_pc    = in_pc;
            nxt_head_instr = in_instr;
          end
        end
        ONE: begin
          if (accept && issue) begin
            nxt_head_pc    = in_pc;
            nxt_head_instr = in_instr;
          end else if (accept) begin
            nxt_state      = FULL;
            nxt_skid_pc    = in_pc;
            nxt_skid_instr = in_instr;
          end else if (issue) begin
            nxt_state      = EMPTY;
            nxt_head_pc    = '0;
            nxt_head_instr = '0;
          end
        end
        FULL: begin
          // Skid promotes to head; in_ready is low so nothing new arrives.
          if (issue) begin
            nxt_state      = ONE;
            nxt_head_pc    = skid_pc;
            nxt_head_instr = skid_instr;
            nxt_skid_pc    = '0;
            nxt_skid_instr = '0;
          end
        end
        default: begin
          // Unused encoding: recover to an empty, zeroed register.
          nxt_state      = EMPTY;
          nxt_head_pc    = '0;
          nxt_head_instr = '0;
          nxt_skid_pc    = '0;
          nxt_skid_instr = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the payload registers are reset too, because an empty register
      // must present an all-zero NOP bubble to decode.
      state      <= EMPTY;
      head_pc    <= '0;
      head_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      state      <= nxt_state;
      head_pc    <= nxt_head_pc;
      head_instr <= nxt_head_instr;
      skid_pc    <= nxt_skid_pc;
      skid_instr <= nxt_skid_instr;
    end
  end

  // Saturating performance counters; cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_hit && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_hit && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule
